// File: rtl/oven_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oven_pkg
// Purpose  : Shared panel state, mode encodings and saturating setpoint math.
// Revision : 1.0
// ============================================================================
package oven_pkg;

    typedef enum logic [1:0] {
        ST_SETUP   = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } panel_state_t;

    localparam logic [1:0] MODE_PREHEAT = 2'd0;
    localparam logic [1:0] MODE_COOK    = 2'd1;
    localparam logic [1:0] MODE_GRILL   = 2'd2;
    localparam logic [1:0] MODE_BAKE    = 2'd3;

    localparam logic [7:0] GRILL_DEF = 8'd90;

    function automatic logic [7:0] sat_add(input logic [7:0] val,
                                           input logic [7:0] step,
                                           input logic [7:0] max);
        logic [8:0] sum;
        sum = {1'b0, val} + {1'b0, step};
        return (sum > {1'b0, max}) ? max : sum[7:0];
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] val,
                                           input logic [7:0] step);
        return (val < step) ? 8'd0 : (val - step);
    endfunction

endpackage
`default_nettype wire

// File: rtl/oven_panel_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Two-flop synchroniser, stability-count debouncer, rising pulse.
// Revision : 1.0
// ============================================================================
module key_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync_q;
    logic [CW-1:0] r_cnt_q;
    logic          r_level_q;
    logic          r_press_q;
    logic [1:0]    w_sync_d;
    logic [CW-1:0] w_cnt_d;
    logic          w_level_d;
    logic          w_press_d;

    always_comb begin
        w_sync_d  = {r_sync_q[0], raw};
        w_cnt_d   = '0;
        w_level_d = r_level_q;
        // Any sample agreeing with the current level restarts the count.
        if (r_sync_q[1] != r_level_q) begin
            if (r_cnt_q == c_cnt_last) begin
                w_level_d = ~r_level_q;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
        w_press_d = w_level_d & ~r_level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_q  <= '0;
            r_cnt_q   <= '0;
            r_level_q <= 1'b0;
            r_press_q <= 1'b0;
        end else begin
            r_sync_q  <= w_sync_d;
            r_cnt_q   <= w_cnt_d;
            r_level_q <= w_level_d;
            r_press_q <= w_press_d;
        end
    end

    assign level = r_level_q;
    assign press = r_press_q;

endmodule
`default_nettype wire

// File: rtl/oven_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : oven_panel_ctrl
// Purpose  : Oven front-panel key handling, setpoints and command generation.
// Revision : 1.0
// ============================================================================
module oven_panel_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DEF_TIME   = 30,
    parameter int DEF_TEMP   = 180,
    parameter int TIME_STEP  = 5,
    parameter int TEMP_STEP  = 10,
    parameter int TIME_MAX   = 240,
    parameter int TEMP_MAX   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       door_open,
    input  logic       heat_active,
    input  logic       buzzer,
    output logic       start_btn,
    output logic       pause_btn,
    output logic [1:0] mode_sel,
    output logic [7:0] set_time,
    output logic [7:0] set_temp,
    output logic       high_grill,
    output logic       edit_temp,
    output logic       lock,
    output logic       done
);
    import oven_pkg::*;

    localparam logic [7:0] c_def_time  = 8'(DEF_TIME);
    localparam logic [7:0] c_def_temp  = 8'(DEF_TEMP);
    localparam logic [7:0] c_time_step = 8'(TIME_STEP);
    localparam logic [7:0] c_temp_step = 8'(TEMP_STEP);
    localparam logic [7:0] c_time_max  = 8'(TIME_MAX);
    localparam logic [7:0] c_temp_max  = 8'(TEMP_MAX);

    logic [4:0] w_raw, w_level, w_press;
    assign w_raw = {key_start, key_pause, key_mode, key_up, key_down};

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (.clk(clk), .rst(rst), .raw(w_raw[4]), .level(w_level[4]), .press(w_press[4]));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (.clk(clk), .rst(rst), .raw(w_raw[3]), .level(w_level[3]), .press(w_press[3]));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode  (.clk(clk), .rst(rst), .raw(w_raw[2]), .level(w_level[2]), .press(w_press[2]));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up    (.clk(clk), .rst(rst), .raw(w_raw[1]), .level(w_level[1]), .press(w_press[1]));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down  (.clk(clk), .rst(rst), .raw(w_raw[0]), .level(w_level[0]), .press(w_press[0]));

    logic w_start_p, w_pause_p, w_mode_p, w_up_p, w_down_p, w_up_held;
    assign {w_start_p, w_pause_p, w_mode_p, w_up_p, w_down_p} = w_press;
    assign w_up_held = w_level[1];

    panel_state_t r_state_q, w_state_d;
    logic [1:0]   r_mode_q, w_mode_d;
    logic [7:0]   r_time_q, w_time_d;
    logic [7:0]   r_temp_q, w_temp_d;
    logic         r_edit_q, w_edit_d;
    logic         r_start_q, w_start_d;
    logic         r_pause_q, w_pause_d;
    logic         r_grill_q, w_grill_d;
    logic         r_lock_q, w_lock_d;
    logic         r_done_q, w_done_d;
    logic         r_heat_low_q, w_heat_low_d;

    always_comb begin
        w_state_d    = r_state_q;
        w_mode_d     = r_mode_q;
        w_time_d     = r_time_q;
        w_temp_d     = r_temp_q;
        w_edit_d     = r_edit_q;
        w_start_d    = 1'b0;
        w_heat_low_d = 1'b0;
        case (r_state_q)
            ST_SETUP: begin
                if (w_start_p && !door_open) begin
                    w_start_d = 1'b1;
                    w_state_d = ST_RUNNING;
                end else if (w_mode_p) begin
                    // Mode with up held is the field-select chord.
                    if (w_up_held) w_edit_d = ~r_edit_q;
                    else           w_mode_d = r_mode_q + 2'd1;
                end else if (w_up_p && !w_down_p) begin
                    if (r_edit_q) w_temp_d = sat_add(r_temp_q, c_temp_step, c_temp_max);
                    else          w_time_d = sat_add(r_time_q, c_time_step, c_time_max);
                end else if (w_down_p && !w_up_p) begin
                    if (r_edit_q) w_temp_d = sat_sub(r_temp_q, c_temp_step);
                    else          w_time_d = sat_sub(r_time_q, c_time_step);
                end
            end
            ST_RUNNING: begin
                if (w_pause_p || door_open) begin
                    w_state_d = ST_PAUSED;
                end else if (buzzer) begin
                    w_state_d = ST_DONE;
                end else if (!heat_active) begin
                    // Heaters idle two cycles running: oven ended on its own.
                    if (r_heat_low_q) w_state_d    = ST_SETUP;
                    else              w_heat_low_d = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (w_pause_p && !door_open) w_state_d = ST_RUNNING;
            end
            ST_DONE: begin
                if ((w_start_p || w_pause_p) && !buzzer) w_state_d = ST_SETUP;
            end
            default: w_state_d = ST_SETUP;
        endcase
        w_pause_d = (w_state_d == ST_PAUSED);
        w_lock_d  = (w_state_d != ST_SETUP);
        w_done_d  = (w_state_d == ST_DONE);
        w_grill_d = (r_time_q != GRILL_DEF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= ST_SETUP;
            r_mode_q     <= MODE_PREHEAT;
            r_time_q     <= c_def_time;
            r_temp_q     <= c_def_temp;
            r_edit_q     <= 1'b0;
            r_start_q    <= 1'b0;
            r_pause_q    <= 1'b0;
            r_grill_q    <= (c_def_time != GRILL_DEF);
            r_lock_q     <= 1'b0;
            r_done_q     <= 1'b0;
            r_heat_low_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_mode_q     <= w_mode_d;
            r_time_q     <= w_time_d;
            r_temp_q     <= w_temp_d;
            r_edit_q     <= w_edit_d;
            r_start_q    <= w_start_d;
            r_pause_q    <= w_pause_d;
            r_grill_q    <= w_grill_d;
            r_lock_q     <= w_lock_d;
            r_done_q     <= w_done_d;
            r_heat_low_q <= w_heat_low_d;
        end
    end

    assign start_btn  = r_start_q;
    assign pause_btn  = r_pause_q;
    assign mode_sel   = r_mode_q;
    assign set_time   = r_time_q;
    assign set_temp   = r_temp_q;
    assign high_grill = r_grill_q;
    assign edit_temp  = r_edit_q;
    assign lock       = r_lock_q;
    assign done       = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_oven_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_oven_panel_ctrl
// Purpose  : Directed, table-driven self-checking bench for oven_panel_ctrl.
// Revision : 1.0
// ============================================================================
module tb_oven_panel_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_start = 0, key_pause = 0, key_mode = 0, key_up = 0, key_down = 0;
    logic       door_open = 0, heat_active = 1, buzzer = 0;
    logic       start_btn, pause_btn, high_grill, edit_temp, lock, done;
    logic [1:0] mode_sel;
    logic [7:0] set_time, set_temp;

    int errors = 0;
    int checks = 0;

    oven_panel_ctrl dut (
        .clk(clk), .rst(rst),
        .key_start(key_start), .key_pause(key_pause), .key_mode(key_mode),
        .key_up(key_up), .key_down(key_down),
        .door_open(door_open), .heat_active(heat_active), .buzzer(buzzer),
        .start_btn(start_btn), .pause_btn(pause_btn), .mode_sel(mode_sel),
        .set_time(set_time), .set_temp(set_temp), .high_grill(high_grill),
        .edit_temp(edit_temp), .lock(lock), .done(done)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] K_S = 5'b10000, K_P = 5'b01000, K_M = 5'b00100,
                           K_U = 5'b00010, K_D = 5'b00001;

    typedef struct {
        logic [4:0] keys;
        logic       e_start;
        logic [1:0] e_mode;
        logic [7:0] e_time;
        logic [7:0] e_temp;
        logic       e_edit;
        logic       e_lock;
        logic       e_pause;
        logic       e_done;
        logic       e_grill;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Press keys, sample start_btn at the 7th edge, then release and settle.
    task automatic press(input logic [4:0] k, output logic pulse);
        @(negedge clk);
        {key_start, key_pause, key_mode, key_up, key_down} = k;
        repeat (7) @(posedge clk);
        #1 pulse = start_btn;
        @(negedge clk);
        {key_start, key_pause, key_mode, key_up, key_down} = '0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Count start_btn pulses over 20 edges; report the edge index of the first.
    task automatic watch_start(output int cnt, output int first);
        cnt = 0; first = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (start_btn) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    logic       p;
    int         n, idx;
    logic       wrapped;
    logic [7:0] prev;

    initial begin
        vecs[0]  = '{K_U,       0, 0, 35, 180, 0, 0, 0, 0, 1};
        vecs[1]  = '{K_U,       0, 0, 40, 180, 0, 0, 0, 0, 1};
        vecs[2]  = '{K_U,       0, 0, 45, 180, 0, 0, 0, 0, 1};
        vecs[3]  = '{K_M,       0, 1, 45, 180, 0, 0, 0, 0, 1};
        vecs[4]  = '{K_M,       0, 2, 45, 180, 0, 0, 0, 0, 1};
        vecs[5]  = '{K_M,       0, 3, 45, 180, 0, 0, 0, 0, 1};
        vecs[6]  = '{K_M,       0, 0, 45, 180, 0, 0, 0, 0, 1};
        vecs[7]  = '{K_M,       0, 1, 45, 180, 0, 0, 0, 0, 1};
        vecs[8]  = '{K_M,       0, 2, 45, 180, 0, 0, 0, 0, 1};
        vecs[9]  = '{K_M,       0, 3, 45, 180, 0, 0, 0, 0, 1};
        vecs[10] = '{K_M,       0, 0, 45, 180, 0, 0, 0, 0, 1};
        vecs[11] = '{K_M,       0, 1, 45, 180, 0, 0, 0, 0, 1};
        vecs[12] = '{K_U | K_D, 0, 1, 45, 180, 0, 0, 0, 0, 1};
        vecs[13] = '{K_S | K_M, 1, 1, 45, 180, 0, 1, 0, 0, 1};
        vecs[14] = '{K_M,       0, 1, 45, 180, 0, 1, 0, 0, 1};
        vecs[15] = '{K_U,       0, 1, 45, 180, 0, 1, 0, 0, 1};
        vecs[16] = '{K_S,       0, 1, 45, 180, 0, 1, 0, 0, 1};
        vecs[17] = '{K_P,       0, 1, 45, 180, 0, 1, 1, 0, 1};
        vecs[18] = '{K_S,       0, 1, 45, 180, 0, 1, 1, 0, 1};
        vecs[19] = '{K_P,       0, 1, 45, 180, 0, 1, 0, 0, 1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_btn", start_btn, 0);
        check("rst_pause_btn", pause_btn, 0);
        check("rst_mode_sel", mode_sel, 0);
        check("rst_set_time", set_time, 30);
        check("rst_set_temp", set_temp, 180);
        check("rst_high_grill", high_grill, 1);
        check("rst_edit_temp", edit_temp, 0);
        check("rst_lock", lock, 0);
        check("rst_done", done, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            press(vecs[i].keys, p);
            check($sformatf("v%0d_start_btn", i), p, vecs[i].e_start);
            check($sformatf("v%0d_mode_sel", i), mode_sel, vecs[i].e_mode);
            check($sformatf("v%0d_set_time", i), set_time, vecs[i].e_time);
            check($sformatf("v%0d_set_temp", i), set_temp, vecs[i].e_temp);
            check($sformatf("v%0d_edit_temp", i), edit_temp, vecs[i].e_edit);
            check($sformatf("v%0d_lock", i), lock, vecs[i].e_lock);
            check($sformatf("v%0d_pause_btn", i), pause_btn, vecs[i].e_pause);
            check($sformatf("v%0d_done", i), done, vecs[i].e_done);
            check($sformatf("v%0d_high_grill", i), high_grill, vecs[i].e_grill);
        end

        // Heaters idle: first low cycle keeps running, second returns to setup.
        @(negedge clk) heat_active = 1'b0;
        @(posedge clk); #1;
        check("heat_low1_lock", lock, 1);
        @(posedge clk); #1;
        check("heat_low2_lock", lock, 0);
        @(negedge clk) heat_active = 1'b1;

        wrapped = 1'b0;
        prev = set_time;
        for (int i = 0; i < 60; i++) begin
            press(K_D, p);
            if (set_time > prev) wrapped = 1'b1;
            prev = set_time;
        end
        check("down_no_wrap", wrapped, 0);
        check("down_sat_time", set_time, 0);
        check("down_high_grill", high_grill, 1);
        for (int i = 0; i < 60; i++) press(K_U, p);
        check("up_sat_time", set_time, 240);

        // Field-select chord: hold up, then press mode.
        @(negedge clk) key_up = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk) key_mode = 1'b1;
        repeat (7) @(posedge clk); #1;
        check("chord_edit_temp", edit_temp, 1);
        check("chord_mode_sel", mode_sel, 1);
        @(negedge clk) {key_up, key_mode} = 2'b00;
        repeat (8) @(posedge clk);
        press(K_U, p);
        check("temp_up1", set_temp, 190);
        for (int i = 0; i < 7; i++) press(K_U, p);
        check("temp_sat", set_temp, 250);
        press(K_D, p);
        check("temp_down", set_temp, 240);
        check("temp_edit_time_kept", set_time, 240);

        // Door handling in RUNNING/PAUSED.
        press(K_S, p);
        check("door_start_pulse", p, 1);
        @(negedge clk) door_open = 1'b1;
        @(posedge clk); #1;
        check("door_pause_btn", pause_btn, 1);
        press(K_P, p);
        check("door_open_resume_ignored", pause_btn, 1);
        @(negedge clk) door_open = 1'b0;
        press(K_P, p);
        check("door_closed_resume_pause", pause_btn, 0);
        check("door_closed_resume_lock", lock, 1);

        // Buzzer ends the cook; presses are ignored until it drops.
        @(negedge clk) buzzer = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("buzz_done", done, 1);
        check("buzz_pause_btn", pause_btn, 0);
        press(K_S, p);
        check("buzz_press_ignored", done, 1);
        @(negedge clk) buzzer = 1'b0;
        press(K_S, p);
        check("done_exit_no_pulse", p, 0);
        check("done_exit_done", done, 0);
        check("done_exit_lock", lock, 0);
        check("done_exit_time", set_time, 240);
        check("done_exit_temp", set_temp, 240);

        // Bouncing start key: 1,0 then stable 1.
        @(negedge clk) key_start = 1'b1;
        @(negedge clk) key_start = 1'b0;
        @(negedge clk) key_start = 1'b1;
        watch_start(n, idx);
        check("bounce_pulse_count", n, 1);
        check("bounce_pulse_latency", idx, 7);
        check("bounce_lock", lock, 1);
        @(negedge clk) key_start = 1'b0;
        repeat (8) @(posedge clk);

        press(K_P, p);
        check("pre_rst_pause_btn", pause_btn, 1);

        // Asynchronous reset mid-cycle while PAUSED, start key held through it.
        @(posedge clk);
        #2 rst = 1'b1;
        key_start = 1'b1;
        #1;
        check("async_rst_pause_btn", pause_btn, 0);
        check("async_rst_set_time", set_time, 30);
        check("async_rst_set_temp", set_temp, 180);
        check("async_rst_lock", lock, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        watch_start(n, idx);
        check("held_rst_pulse_count", n, 1);
        check("held_rst_pulse_latency", idx, 7);
        @(negedge clk) key_start = 1'b0;
        repeat (8) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
